// File: rtl/booth_radix4_multiplier_pkg.sv
// booth_pkg: shared FSM states, Booth digit encoding and radix-4 recoder
package booth_pkg;
  typedef enum logic {IDLE, RUN} booth_state_t;
  typedef enum logic [2:0] {DIG_0, DIG_P1, DIG_P2, DIG_M1, DIG_M2} booth_digit_t;
  function automatic booth_digit_t booth_recode(input logic [2:0] t);
    return (t == 3'b001 || t == 3'b010) ? DIG_P1 :
           (t == 3'b011)                ? DIG_P2 :
           (t == 3'b100)                ? DIG_M2 :
           (t == 3'b101 || t == 3'b110) ? DIG_M1 : DIG_0;
  endfunction
endpackage

// File: rtl/booth_radix4_multiplier_addsub.sv
// booth_addsub: combinational adder with carry-in, used for both add and subtract steps
module booth_addsub #(
  parameter int WD = 12
) (
  input  logic [WD-1:0] a,
  input  logic [WD-1:0] b,
  input  logic          cin,
  output logic [WD-1:0] sum
);
  assign sum = a + b + {{(WD-1){1'b0}}, cin};
endmodule

// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier: iterative radix-4 Booth multiplier, signed/unsigned, start/busy/done
module booth_radix4_multiplier
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_signed,
  input  logic [W-1:0]   mc,
  input  logic [W-1:0]   mp,
  output logic [2*W-1:0] prod,
  output logic           busy,
  output logic           done
);
  localparam int ITER = W / 2 + 1;
  localparam int CW   = $clog2(ITER + 1);
  localparam int N    = W + 2;
  localparam int AW   = N + 2;
  generate
    if (W % 2 != 0 || W < 4) begin : g_bad_w
      $error("booth_radix4_multiplier: W must be even and >= 4");
    end
  endgenerate
  booth_state_t   r_state, w_state_nxt;
  booth_digit_t   w_dig;
  logic [AW-1:0]  r_a, r_m, w_addend, w_sum, w_a_sh;
  logic [N-1:0]   r_q, w_q_sh;
  logic           r_q1, w_cin, w_last, w_load;
  logic [CW-1:0]  r_cnt;
  assign w_dig = booth_recode({r_q[1:0], r_q1});
  // Negative digits use the inverted addend plus carry-in so a single adder serves all cases
  always_comb begin
    w_addend = (w_dig == DIG_P1) ? r_m :
               (w_dig == DIG_P2) ? (r_m << 1) :
               (w_dig == DIG_M1) ? ~r_m :
               (w_dig == DIG_M2) ? ~(r_m << 1) : '0;
    w_cin    = (w_dig == DIG_M1) || (w_dig == DIG_M2);
  end
  booth_addsub #(.WD(AW)) u_addsub (
    .a  (r_a),
    .b  (w_addend),
    .cin(w_cin),
    .sum(w_sum)
  );
  assign w_a_sh = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
  assign w_q_sh = {w_sum[1:0], r_q[N-1:2]};
  assign w_last = r_cnt == CW'(ITER - 1);
  assign w_load = (r_state == IDLE) && start;
  assign busy   = r_state == RUN;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = (r_state == IDLE) ? (start ? RUN : IDLE) : (w_last ? IDLE : RUN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      prod  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_load) begin
        r_a   <= '0;
        r_m   <= {{(AW-W){is_signed & mc[W-1]}}, mc};
        r_q   <= {{(N-W){is_signed & mp[W-1]}}, mp};
        r_q1  <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_a   <= w_a_sh;
        r_q   <= w_q_sh;
        r_q1  <= r_q[1];
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          prod <= {w_a_sh[2*W-N-1:0], w_q_sh};
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// tb_booth_radix4_multiplier: random and directed checks of W=8 and W=4 instances against an arithmetic model
module tb_booth_radix4_multiplier;
  logic clk = 1'b0, rst = 1'b1;
  logic start8 = 1'b0, sg8 = 1'b0, start4 = 1'b0, sg4 = 1'b0;
  logic [7:0] mc8 = '0, mp8 = '0;
  logic [3:0] mc4 = '0, mp4 = '0;
  logic [15:0] prod8;
  logic [7:0] prod4;
  logic busy8, done8, busy4, done4;
  int vectors = 0, errors = 0;
  logic [15:0] e8_prod, e8_pend;
  logic [7:0]  e4_prod, e4_pend;
  logic e8_done, e4_done;
  int e8_cnt = 0, e4_cnt = 0;

  booth_radix4_multiplier #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sg8), .mc(mc8), .mp(mp8),
    .prod(prod8), .busy(busy8), .done(done8)
  );
  booth_radix4_multiplier #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .is_signed(sg4), .mc(mc4), .mp(mp4),
    .prod(prod4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, b, input logic s, input int w);
    longint x, y, p;
    x = longint'(a) & ((longint'(1) << w) - 1);
    y = longint'(b) & ((longint'(1) << w) - 1);
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return p[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timing model: an accepted start completes ITER edges later; rst cancels everything
  always @(posedge clk) begin
    e8_done <= 1'b0;
    e4_done <= 1'b0;
    if (rst) begin
      e8_cnt <= 0; e8_prod <= '0;
      e4_cnt <= 0; e4_prod <= '0;
    end else begin
      if (e8_cnt != 0) begin
        e8_cnt <= e8_cnt - 1;
        if (e8_cnt == 1) begin e8_prod <= e8_pend; e8_done <= 1'b1; end
      end else if (start8) begin
        e8_cnt <= 5; e8_pend <= ref_mul(mc8, mp8, sg8, 8);
      end
      if (e4_cnt != 0) begin
        e4_cnt <= e4_cnt - 1;
        if (e4_cnt == 1) begin e4_prod <= e4_pend; e4_done <= 1'b1; end
      end else if (start4) begin
        e4_cnt <= 3; e4_pend <= 8'(ref_mul({4'b0, mc4}, {4'b0, mp4}, sg4, 4));
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    chk("busy8", 32'(busy8), 32'(e8_cnt != 0));
    chk("done8", 32'(done8), 32'(e8_done));
    chk("prod8", 32'(prod8), 32'(e8_prod));
    chk("busy4", 32'(busy4), 32'(e4_cnt != 0));
    chk("done4", 32'(done4), 32'(e4_done));
    chk("prod4", 32'(prod4), 32'(e4_prod));
  end

  task automatic go8(input logic s, input logic [7:0] a, b);
    @(negedge clk); sg8 = s; mc8 = a; mp8 = b; start8 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait8(input string nm, input logic [15:0] exp, input int elapsed);
    int lat = 0;
    for (int k = elapsed + 1; k <= 12 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done8) lat = k;
    end
    chk({nm, "_lat"}, 32'(lat), 32'd5);
    chk(nm, 32'(prod8), 32'(exp));
  endtask

  task automatic op4(input logic s, input logic [3:0] a, b);
    int lat = 0;
    logic [7:0] exp;
    exp = 8'(ref_mul({4'b0, a}, {4'b0, b}, s, 4));
    @(negedge clk); sg4 = s; mc4 = a; mp4 = b; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done4) lat = k;
    end
    chk("w4_lat", 32'(lat), 32'd3);
    chk("w4_prod", 32'(prod4), 32'(exp));
  endtask

  initial begin
    int quiet;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_prod8", 32'(prod8), 32'h0);
    chk("rst_busy8", 32'(busy8), 32'h0);
    chk("rst_done8", 32'(done8), 32'h0);
    @(negedge clk); rst = 1'b0;
    go8(1'b1, 8'hF9, 8'd3);   start8 = 1'b0; wait8("neg7x3", 16'hFFEB, 0);
    go8(1'b0, 8'hFF, 8'hFF);  start8 = 1'b0; wait8("u255x255", 16'hFE01, 0);
    go8(1'b1, 8'hFF, 8'hFF);  start8 = 1'b0; wait8("s_m1xm1", 16'h0001, 0);
    go8(1'b1, 8'h80, 8'h80);  start8 = 1'b0; wait8("m128xm128", 16'h4000, 0);
    go8(1'b1, 8'h7F, 8'h80);  start8 = 1'b0; wait8("127xm128", 16'hC080, 0);
    go8(1'b1, 8'h00, 8'hFF);  start8 = 1'b0; wait8("0xm1", 16'h0000, 0);
    go8(1'b1, 8'hF9, 8'd3);
    mc8 = 8'd5; mp8 = 8'd9; sg8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start8 = 1'b0;
    wait8("hold_start", 16'hFFEB, 3);
    go8(1'b0, 8'd20, 8'd13);  start8 = 1'b0; wait8("seq1", 16'd260, 0);
    sg8 = 1'b1; mc8 = 8'hFE; mp8 = 8'd100; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    wait8("seq2_done_cycle", 16'hFF38, 0);
    go8(1'b0, 8'd7, 8'd6);    start8 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy8), 32'h0);
    chk("abort_done", 32'(done8), 32'h0);
    chk("abort_prod", 32'(prod8), 32'h0);
    @(negedge clk); rst = 1'b0;
    quiet = 0;
    repeat (8) begin @(posedge clk); #1; if (done8) quiet++; end
    chk("abort_no_done", 32'(quiet), 32'h0);
    go8(1'b0, 8'd12, 8'd11);  start8 = 1'b0; wait8("after_abort", 16'd132, 0);
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          op4(1'(s), 4'(a), 4'(b));
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst    = $urandom_range(0, 299) == 0;
      start8 = $urandom_range(0, 3) == 0;
      start4 = $urandom_range(0, 3) == 0;
      sg8 = 1'($urandom); mc8 = 8'($urandom); mp8 = 8'($urandom);
      sg4 = 1'($urandom); mc4 = 4'($urandom); mp4 = 4'($urandom);
    end
    @(negedge clk); rst = 1'b0; start8 = 1'b0; start4 = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
